// File: rtl/uart_loopback_fifo.sv
// Buffered UART echo: rx bytes queue in a FIFO and are re-sent (optional CR->CR LF, or sink-only).
// Latency rx->tx write 2 clocks; stalls on tx_ready_i, drops on full FIFO with sticky overflow_o.
module uart_loopback_fifo #(
    parameter int DEPTH_LOG2     = 4,
    parameter int STRETCH_CYCLES = 600000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_write_o,
    input  logic                   tx_ready_i,
    input  logic [1:0]             mode_i,
    output logic                   led_rx_o,
    output logic                   led_tx_o,
    output logic                   overflow_o,
    output logic [COUNT_WIDTH-1:0] rx_count_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LED_W = $clog2(STRETCH_CYCLES + 1);

    localparam logic [DEPTH_LOG2:0]   OCC_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   OCC_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [LED_W-1:0]      LED_LOAD  = LED_W'(STRETCH_CYCLES);
    localparam logic [LED_W-1:0]      LED_ONE   = LED_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_LF_WAIT = 2'd2
    } state_t;

    logic [7:0]             r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_occ;
    state_t                 r_state;
    logic                   r_lf_pend;
    logic [7:0]             r_tx_data;
    logic                   r_tx_write;
    logic                   r_overflow;
    logic [COUNT_WIDTH-1:0] r_rx_count;
    logic [LED_W-1:0]       r_led_rx_cnt;
    logic [LED_W-1:0]       r_led_tx_cnt;

    logic       w_full;
    logic       w_empty;
    logic       w_sink;
    logic       w_push;
    logic       w_drop;
    logic       w_pop;
    logic [7:0] w_head;

    assign w_full  = (r_occ == OCC_FULL);
    assign w_empty = (r_occ == '0);
    assign w_sink  = (mode_i == 2'd2);
    assign w_push  = rx_valid_i && !w_sink && !w_full;
    assign w_drop  = rx_valid_i && !w_sink && w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && tx_ready_i;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= rx_data_i;
        end
    end

    // Full is judged on the start-of-cycle occupancy, so a same-cycle pop never rescues a push.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_ONE;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OCC_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_rx_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (rx_valid_i) begin
                r_rx_count <= r_rx_count + CNT_ONE;
            end
        end
    end

    // HOLD masks tx_ready_i for one cycle while the transmitter reacts to the last write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lf_pend  <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_write <= 1'b0;
        end else begin
            r_tx_write <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_head;
                        r_tx_write <= 1'b1;
                        r_lf_pend  <= (mode_i == 2'd1) && (w_head == 8'h0D);
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_state <= r_lf_pend ? S_LF_WAIT : S_IDLE;
                end
                S_LF_WAIT: begin
                    if (tx_ready_i) begin
                        r_tx_data  <= 8'h0A;
                        r_tx_write <= 1'b1;
                        r_lf_pend  <= 1'b0;
                        r_state    <= S_HOLD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_led_rx_cnt <= '0;
        end else if (rx_valid_i) begin
            r_led_rx_cnt <= LED_LOAD;
        end else if (r_led_rx_cnt != '0) begin
            r_led_rx_cnt <= r_led_rx_cnt - LED_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_led_tx_cnt <= '0;
        end else if (r_tx_write) begin
            r_led_tx_cnt <= LED_LOAD;
        end else if (r_led_tx_cnt != '0) begin
            r_led_tx_cnt <= r_led_tx_cnt - LED_ONE;
        end
    end

    assign tx_data_o  = r_tx_data;
    assign tx_write_o = r_tx_write;
    assign overflow_o = r_overflow;
    assign rx_count_o = r_rx_count;
    assign led_rx_o   = (r_led_rx_cnt != '0);
    assign led_tx_o   = (r_led_tx_cnt != '0);

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Scoreboard bench for uart_loopback_fifo: a queue-level model predicts every tx write and status output.
module tb_uart_loopback_fifo;
    localparam int DL    = 2;
    localparam int SC    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          tx_ready = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    tx_data;
    logic          tx_write;
    logic          led_rx;
    logic          led_tx;
    logic          overflow;
    logic [CW-1:0] rx_count;

    uart_loopback_fifo #(.DEPTH_LOG2(DL), .STRETCH_CYCLES(SC), .COUNT_WIDTH(CW)) dut (
        .clock      (clk),
        .reset      (reset),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data),
        .tx_write_o (tx_write),
        .tx_ready_i (tx_ready),
        .mode_i     (mode),
        .led_rx_o   (led_rx),
        .led_tx_o   (led_tx),
        .overflow_o (overflow),
        .rx_count_o (rx_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    // Reference model: byte queue, a pending-LF flag and a one-cycle post-write blackout.
    int         cyc = 0;
    exp_t       expq[$];
    logic [7:0] mq[$];
    bit         m_lf = 0;
    bit         m_hold = 0;
    bit         m_ovf = 0;
    bit         m_wr_prev = 0;
    logic [15:0] m_cnt = 0;
    int         m_led_rx = 0;
    int         m_led_tx = 0;

    always @(posedge clk) begin
        bit         full;
        bit         wr;
        logic [7:0] b;
        cyc++;
        wr = 0;
        if (reset) begin
            mq.delete();
            expq.delete();
            m_lf = 0; m_hold = 0; m_ovf = 0; m_cnt = 0;
            m_led_rx = 0; m_led_tx = 0;
        end else begin
            full = (mq.size() == DEPTH);
            if (m_hold) begin
                m_hold = 0;
            end else if (m_lf) begin
                if (tx_ready) begin
                    expq.push_back('{d: 8'h0A, c: cyc});
                    m_lf = 0; m_hold = 1; wr = 1;
                end
            end else if (mq.size() != 0 && tx_ready) begin
                b = mq.pop_front();
                expq.push_back('{d: b, c: cyc});
                m_lf = (mode == 2'd1) && (b == 8'h0D);
                m_hold = 1; wr = 1;
            end
            if (rx_valid) begin
                m_cnt++;
                if (mode != 2'd2) begin
                    if (full) m_ovf = 1;
                    else mq.push_back(rx_data);
                end
            end
            m_led_rx = rx_valid ? SC : (m_led_rx > 0 ? m_led_rx - 1 : 0);
            m_led_tx = m_wr_prev ? SC : (m_led_tx > 0 ? m_led_tx - 1 : 0);
        end
        m_wr_prev = wr;
    end

    logic [7:0] txlog[$];
    int         last_wr = -100;

    always @(negedge clk) begin
        exp_t e;
        if (tx_write) begin
            txlog.push_back(tx_data);
            chk("tx_spacing", 32'(cyc - last_wr >= 2), 1);
            last_wr = cyc;
            if (expq.size() == 0) begin
                chk("tx_unexpected_write", tx_write, 0);
            end else begin
                e = expq.pop_front();
                chk("tx_data", tx_data, e.d);
                chk("tx_cycle", cyc, e.c);
            end
        end else if (expq.size() != 0 && expq[0].c <= cyc) begin
            e = expq.pop_front();
            chk("tx_missing_write", tx_write, 1);
        end
        chk("overflow", overflow, m_ovf);
        chk("rx_count", rx_count, m_cnt);
        chk("led_rx", led_rx, m_led_rx != 0);
        chk("led_tx", led_tx, m_led_tx != 0);
    end

    function automatic logic [31:0] logat(int i);
        if (i < txlog.size()) return {24'h0, txlog[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        chk("rst_tx_write", tx_write, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_leds", {led_rx, led_tx}, 0);

        // Echo with fixed latency and LED window
        mode = 2'd0; tx_ready = 1'b1; txlog.delete();
        send(8'h41);
        chk("echo_k1_nowrite", tx_write, 0);
        chk("echo_count", rx_count, 1);
        chk("echo_led_first", led_rx, 1);
        tick(1);
        chk("echo_k2_write", tx_write, 1);
        chk("echo_k2_data", tx_data, 8'h41);
        tick(6);
        chk("echo_led_last", led_rx, 1);
        tick(1);
        chk("echo_led_off", led_rx, 0);

        // CR expansion in mode 1, none in mode 0
        tick(4); txlog.delete(); mode = 2'd1;
        send(8'h0D); send(8'h42); tick(12);
        chk("cr1_n", txlog.size(), 3);
        chk("cr1_b0", logat(0), 8'h0D);
        chk("cr1_b1", logat(1), 8'h0A);
        chk("cr1_b2", logat(2), 8'h42);
        txlog.delete(); mode = 2'd0;
        send(8'h0D); send(8'h42); tick(12);
        chk("cr0_n", txlog.size(), 2);
        chk("cr0_b0", logat(0), 8'h0D);
        chk("cr0_b1", logat(1), 8'h42);

        // Overflow on a full FIFO
        do_reset(); tx_ready = 1'b0; mode = 2'd0;
        for (int i = 1; i <= 6; i++) send(8'(i));
        chk("ovf_set", overflow, 1);
        chk("ovf_count", rx_count, 6);
        txlog.delete(); tx_ready = 1'b1; tick(14);
        chk("ovf_n", txlog.size(), 4);
        for (int i = 0; i < 4; i++) chk("ovf_byte", logat(i), 32'(i + 1));
        chk("ovf_sticky", overflow, 1);

        // Sink mode and backpressure
        do_reset(); mode = 2'd2; tx_ready = 1'b1; txlog.delete();
        send(8'hA1); send(8'hA2); send(8'hA3); tick(6);
        chk("sink_count", rx_count, 3);
        chk("sink_n", txlog.size(), 0);
        mode = 2'd0; tx_ready = 1'b0;
        send(8'h55); tick(6);
        chk("bp_stalled_n", txlog.size(), 0);
        tx_ready = 1'b1; tick(4);
        chk("bp_released_n", txlog.size(), 1);
        chk("bp_byte", logat(0), 8'h55);

        // Reset while waiting to send LF with bytes queued
        mode = 2'd1; tx_ready = 1'b1; txlog.delete();
        send(8'h0D); tick(1);
        tx_ready = 1'b0;
        send(8'h11); send(8'h22); tick(2);
        reset = 1'b1; tick(1);
        chk("lfrst_tx_write", tx_write, 0);
        chk("lfrst_tx_data", tx_data, 0);
        chk("lfrst_leds", {led_rx, led_tx}, 0);
        chk("lfrst_overflow", overflow, 0);
        chk("lfrst_count", rx_count, 0);
        reset = 1'b0; txlog.delete(); tx_ready = 1'b1; tick(20);
        chk("lfrst_no_stale", txlog.size(), 0);

        // Counter wrap
        do_reset(); mode = 2'd2; rx_valid = 1'b1;
        tick(65535);
        chk("wrap_allones", rx_count, 16'hFFFF);
        tick(1);
        rx_valid = 1'b0;
        chk("wrap_zero", rx_count, 0);

        // LED retrigger
        tick(12);
        send(8'h01);
        chk("led_re_start", led_rx, 1);
        tick(4);
        send(8'h02);
        tick(3);
        chk("led_re_extended", led_rx, 1);
        tick(4);
        chk("led_re_last", led_rx, 1);
        tick(1);
        chk("led_re_off", led_rx, 0);

        // Randomized traffic with mode changes and random transmitter readiness
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) mode = 2'($urandom_range(0, 3));
            rx_valid = ($urandom_range(0, 9) < 4);
            rx_data  = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
            tx_ready = ($urandom_range(0, 9) < 6);
            tick(1);
        end
        rx_valid = 1'b0; tx_ready = 1'b1; tick(30);
        chk("rand_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
